// File: rtl/enc_bpv_pack_if.sv
// Handshake and data bundle for the BPV packer: one packet in, one packed
// word out. The master side drives packets and consumes words; the slave
// side is the packer itself.
interface enc_bpv_pack_if;
  logic         in_valid;
  logic         in_ready;
  logic         use2x2;
  logic [7:0]   bpv0;
  logic [7:0]   bpv1;
  logic [127:0] coef_bits;
  logic [7:0]   coef_size;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_size;
  logic [1:0]   out_ssm;
  logic         err;

  modport master (
    output in_valid, use2x2, bpv0, bpv1, coef_bits, coef_size, out_ready,
    input  in_ready, out_valid, out_data, out_size, out_ssm, err
  );

  modport slave (
    input  in_valid, use2x2, bpv0, bpv1, coef_bits, coef_size, out_ready,
    output in_ready, out_valid, out_data, out_size, out_ssm, err
  );
endinterface

// File: rtl/enc_bpv_pack.sv
// BPV suffix packer: places one (2x2) or two (2x1) block prediction vector
// fields at the top of a 128-bit word, follows them with the valid
// coefficient bits, and reports the total length plus a range/overflow flag.
// Three-state flow: capture in IDLE, compute in PACK, present in HOLD.
module enc_bpv_pack #(
  parameter int SSM_IDX      = 0,
  parameter int BPV_NUM_BITS = 6,
  parameter int IS_FLS       = 1
) (
  input logic           clk,
  input logic           rst_n,
  enc_bpv_pack_if.slave bus
);

  // Field width shrinks by one in FLS mode because the stored value is bpv-32.
  localparam int           W          = (IS_FLS != 0) ? BPV_NUM_BITS - 1 : BPV_NUM_BITS;
  localparam logic [127:0] FIELD_MASK = (128'd1 << W) - 128'd1;
  localparam logic [127:0] BPV_OFFSET = (IS_FLS != 0) ? 128'd32 : 128'd0;
  localparam logic [8:0]   BPV_HI     = 9'(32 + (1 << W) - 1);

  if (W < 1 || W > 7) begin : g_bad_width
    $error("enc_bpv_pack: BPV field width must be within 1..7");
  end

  typedef enum logic [1:0] {IDLE, PACK, HOLD} state_e;

  state_e       state_q, state_d;
  logic         use2x2_q, use2x2_d;
  logic [7:0]   bpv0_q, bpv0_d;
  logic [7:0]   bpv1_q, bpv1_d;
  logic [127:0] coef_bits_q, coef_bits_d;
  logic [7:0]   coef_size_q, coef_size_d;
  logic [127:0] out_data_q, out_data_d;
  logic [7:0]   out_size_q, out_size_d;
  logic         err_q, err_d;

  logic [127:0] field0, field1, header, coef_mask, packed_data;
  logic [7:0]   bpv_len, packed_size;
  logic [8:0]   size_sum;
  logic         bad0, bad1, packed_err;

  // Pure packing arithmetic on the captured packet; consumed only in PACK.
  always_comb begin
    field0      = (128'(bpv0_q) - BPV_OFFSET) & FIELD_MASK;
    field1      = (128'(bpv1_q) - BPV_OFFSET) & FIELD_MASK;
    bpv_len     = use2x2_q ? 8'(W) : 8'(2 * W);
    header      = field0 << (128 - W);
    if (!use2x2_q) begin
      header = header | (field1 << (128 - 2 * W));
    end
    // Top coef_size bits kept; sizes of 128 and above keep the whole word.
    coef_mask   = ~({128{1'b1}} >> coef_size_q);
    packed_data = header | ((coef_bits_q & coef_mask) >> bpv_len);
    size_sum    = {1'b0, bpv_len} + {1'b0, coef_size_q};
    packed_size = (size_sum > 9'd128) ? 8'd128 : size_sum[7:0];
    bad0        = (bpv0_q < 8'd32) || ({1'b0, bpv0_q} > BPV_HI);
    bad1        = (bpv1_q < 8'd32) || ({1'b0, bpv1_q} > BPV_HI);
    packed_err  = (size_sum > 9'd128) || (coef_size_q > 8'd128) ||
                  ((IS_FLS != 0) && (bad0 || (!use2x2_q && bad1)));
  end

  // Next-state and register-update decisions for the capture/pack/hold flow.
  always_comb begin
    state_d     = state_q;
    use2x2_d    = use2x2_q;
    bpv0_d      = bpv0_q;
    bpv1_d      = bpv1_q;
    coef_bits_d = coef_bits_q;
    coef_size_d = coef_size_q;
    out_data_d  = out_data_q;
    out_size_d  = out_size_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          use2x2_d    = bus.use2x2;
          bpv0_d      = bus.bpv0;
          bpv1_d      = bus.bpv1;
          coef_bits_d = bus.coef_bits;
          coef_size_d = bus.coef_size;
          state_d     = PACK;
        end
      end
      PACK: begin
        out_data_d = packed_data;
        out_size_d = packed_size;
        err_d      = packed_err;
        state_d    = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset drops any pending packet at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      use2x2_q    <= 1'b0;
      bpv0_q      <= 8'd0;
      bpv1_q      <= 8'd0;
      coef_bits_q <= 128'd0;
      coef_size_q <= 8'd0;
      out_data_q  <= 128'd0;
      out_size_q  <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      use2x2_q    <= use2x2_d;
      bpv0_q      <= bpv0_d;
      bpv1_q      <= bpv1_d;
      coef_bits_q <= coef_bits_d;
      coef_size_q <= coef_size_d;
      out_data_q  <= out_data_d;
      out_size_q  <= out_size_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_size  = out_size_q;
  assign bus.err       = err_q;
  assign bus.out_ssm   = 2'(SSM_IDX);

endmodule

// File: tb/tb_enc_bpv_pack.sv
// Directed and round-trip bench for enc_bpv_pack with default field width 5.
module tb_enc_bpv_pack;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enc_bpv_pack_if bus();

  enc_bpv_pack #(.SSM_IDX(2), .BPV_NUM_BITS(6), .IS_FLS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic         use2x2;
    logic [7:0]   bpv0;
    logic [7:0]   bpv1;
    logic [127:0] coef_bits;
    logic [7:0]   coef_size;
    logic [127:0] exp_data;
    logic [7:0]   exp_size;
    logic         exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one packet, confirm acceptance and the one-cycle PACK gap, end in HOLD.
  task automatic applyStimulus(input vec_t v);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({v.name, "_ready"}, 128'(bus.in_ready), 128'd1);
    bus.use2x2    = v.use2x2;
    bus.bpv0      = v.bpv0;
    bus.bpv1      = v.bpv1;
    bus.coef_bits = v.coef_bits;
    bus.coef_size = v.coef_size;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({v.name, "_pack_valid"}, 128'(bus.out_valid), 128'd0);
    check({v.name, "_pack_ready"}, 128'(bus.in_ready), 128'd0);
    @(posedge clk); #1;
    check({v.name, "_hold_valid"}, 128'(bus.out_valid), 128'd1);
  endtask

  // Compare the held word, then release it and confirm return to IDLE.
  task automatic checkOutput(input vec_t v);
    check({v.name, "_data"}, bus.out_data, v.exp_data);
    check({v.name, "_size"}, 128'(bus.out_size), 128'(v.exp_size));
    check({v.name, "_err"}, 128'(bus.err), 128'(v.exp_err));
    check({v.name, "_ssm"}, 128'(bus.out_ssm), 128'd2);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({v.name, "_idle_valid"}, 128'(bus.out_valid), 128'd0);
    check({v.name, "_idle_ready"}, 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    vec_t         rv;
    logic [127:0] mask;
    int           len;

    vecs[0] = '{"v2x2", 1'b1, 8'd45, 8'd0, 128'hF000_0000_0000_0000_0000_0000_0000_0000, 8'd4,
                128'h6F80_0000_0000_0000_0000_0000_0000_0000, 8'd9, 1'b0};
    vecs[1] = '{"v2x1_empty", 1'b0, 8'd32, 8'd63, {128{1'b1}}, 8'd0,
                128'h07C0_0000_0000_0000_0000_0000_0000_0000, 8'd10, 1'b0};
    vecs[2] = '{"v_overflow", 1'b0, 8'd40, 8'd33, {128{1'b1}}, 8'd128,
                128'h407F_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 8'd128, 1'b1};
    vecs[3] = '{"v_range0", 1'b1, 8'd20, 8'd0, 128'd0, 8'd0,
                128'hA000_0000_0000_0000_0000_0000_0000_0000, 8'd5, 1'b1};
    vecs[4] = '{"v_range1", 1'b0, 8'd63, 8'd64, 128'd0, 8'd0,
                128'hF800_0000_0000_0000_0000_0000_0000_0000, 8'd10, 1'b1};
    vecs[5] = '{"v_bpv1_ignored", 1'b1, 8'd32, 8'd200, {8{16'hAAAA}}, 8'd8,
                128'h0550_0000_0000_0000_0000_0000_0000_0000, 8'd13, 1'b0};
    vecs[6] = '{"v_mask", 1'b0, 8'd33, 8'd34, {128{1'b1}}, 8'd3,
                128'h08B8_0000_0000_0000_0000_0000_0000_0000, 8'd13, 1'b0};
    vecs[7] = '{"v_exact128", 1'b1, 8'd63, 8'd0, {128{1'b1}}, 8'd123,
                {128{1'b1}}, 8'd128, 1'b0};
    vecs[8] = '{"v_sum129", 1'b1, 8'd32, 8'd0, {128{1'b1}}, 8'd124,
                128'h07FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 8'd128, 1'b1};
    vecs[9] = '{"v_size200", 1'b1, 8'd50, 8'd0, 128'd0, 8'd200,
                128'h9000_0000_0000_0000_0000_0000_0000_0000, 8'd128, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.use2x2    = 1'b0;
    bus.bpv0      = 8'd0;
    bus.bpv1      = 8'd0;
    bus.coef_bits = 128'd0;
    bus.coef_size = 8'd0;

    // Reset values while held in reset.
    #12;
    check("rst_valid", 128'(bus.out_valid), 128'd0);
    check("rst_data", bus.out_data, 128'd0);
    check("rst_size", 128'(bus.out_size), 128'd0);
    check("rst_err", 128'(bus.err), 128'd0);

    // First accept on the first rising edge after release.
    @(negedge clk);
    rst_n         = 1'b1;
    bus.use2x2    = vecs[1].use2x2;
    bus.bpv0      = vecs[1].bpv0;
    bus.bpv1      = vecs[1].bpv1;
    bus.coef_bits = vecs[1].coef_bits;
    bus.coef_size = vecs[1].coef_size;
    bus.in_valid  = 1'b1;
    #1;
    check("rel_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("first_accept", 128'(bus.in_ready), 128'd0);
    check("first_pack_valid", 128'(bus.out_valid), 128'd0);
    @(posedge clk); #1;
    check("first_hold_valid", 128'(bus.out_valid), 128'd1);
    checkOutput(vecs[1]);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Backpressure: HOLD stays put while in_valid toggles with other data.
    applyStimulus(vecs[0]);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = ~bus.in_valid;
      bus.bpv0      = 8'(40 + i);
      bus.use2x2    = 1'b0;
      bus.coef_size = 8'd7;
      @(posedge clk); #1;
      check("bp_valid", 128'(bus.out_valid), 128'd1);
      check("bp_ready", 128'(bus.in_ready), 128'd0);
      check("bp_data", bus.out_data, vecs[0].exp_data);
      check("bp_size", 128'(bus.out_size), 128'(vecs[0].exp_size));
    end
    bus.in_valid = 1'b0;
    checkOutput(vecs[0]);
    applyStimulus(vecs[6]);
    checkOutput(vecs[6]);

    // Reset during PACK drops the packet.
    applyStimulus(vecs[2]);
    checkOutput(vecs[2]);
    bus.use2x2    = vecs[3].use2x2;
    bus.bpv0      = vecs[3].bpv0;
    bus.coef_bits = vecs[3].coef_bits;
    bus.coef_size = vecs[3].coef_size;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("rstpack_state", 128'(bus.in_ready), 128'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstpack_valid", 128'(bus.out_valid), 128'd0);
    check("rstpack_data", bus.out_data, 128'd0);
    check("rstpack_err", 128'(bus.err), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rstpack_no_word", 128'(bus.out_valid), 128'd0);
      check("rstpack_idle", 128'(bus.in_ready), 128'd1);
    end
    bus.out_ready = 1'b0;

    // Reset during HOLD drops the word immediately.
    applyStimulus(vecs[4]);
    #2 rst_n = 1'b0;
    #1;
    check("rsthold_valid", 128'(bus.out_valid), 128'd0);
    check("rsthold_data", bus.out_data, 128'd0);
    check("rsthold_size", 128'(bus.out_size), 128'd0);
    check("rsthold_err", 128'(bus.err), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rsthold_ready", 128'(bus.in_ready), 128'd1);

    // Round trip through a field decoder on random legal packets.
    for (int k = 0; k < 1000; k++) begin
      rv.name      = "rt";
      rv.use2x2    = 1'($urandom_range(0, 1));
      rv.bpv0      = 8'($urandom_range(32, 63));
      rv.bpv1      = 8'($urandom_range(32, 63));
      len          = rv.use2x2 ? W : 2 * W;
      rv.coef_size = 8'($urandom_range(0, 128 - len));
      rv.coef_bits = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(rv);
      check("rt_bpv0", 128'({3'b0, bus.out_data[127 -: W]} + 8'd32), 128'(rv.bpv0));
      if (!rv.use2x2) begin
        check("rt_bpv1", 128'({3'b0, bus.out_data[127 - W -: W]} + 8'd32), 128'(rv.bpv1));
      end
      check("rt_size", 128'(bus.out_size), 128'(len + int'(rv.coef_size)));
      check("rt_err", 128'(bus.err), 128'd0);
      mask = 128'd0;
      for (int b = 0; b < int'(rv.coef_size); b++) mask[127 - b] = 1'b1;
      check("rt_coef", bus.out_data << len, rv.coef_bits & mask);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enc_bpv_pack.md
ENC_BPV_PACK -- requirements
Module: enc_bpv_pack

Interface
REQ-001 SHALL have parameter SSM_IDX, default 0: substream index tag, copied to out_ssm.
REQ-002 SHALL have parameter BPV_NUM_BITS, default 6: coded BPV width before the FLS reduction.
REQ-003 SHALL have parameter IS_FLS, default 1: FLS mode; field width is BPV_NUM_BITS-1 and the stored value is bpv-32.
REQ-004 Ports (clock and reset first):
  clk  in  1  single clock; all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  input packet valid
  in_ready  out  1  block can accept a packet
  use2x2  in  1  1: one 2x2 BPV (bpv0 only); 0: two 2x1 BPVs (bpv0, bpv1)
  bpv0  in  8  first block prediction vector
  bpv1  in  8  second BPV; ignored when use2x2=1
  coef_bits  in  128  coefficient-group bits, MSB-aligned
  coef_size  in  8  valid bit count of coef_bits, 0..128
  out_valid  out  1  packed word valid
  out_ready  in  1  downstream accepts the packed word
  out_data  out  128  packed suffix, MSB-first
  out_size  out  8  valid bit count of out_data
  out_ssm  out  2  equals SSM_IDX[1:0]
  err  out  1  range or overflow error for the current word
REQ-005 Clock port SHALL be named clk; reset SHALL be rst_n, asynchronous, active-low.

Function
REQ-006 Field width W SHALL be IS_FLS ? BPV_NUM_BITS-1 : BPV_NUM_BITS (5 by default); W outside 1..7 is illegal.
REQ-007 BPV field value SHALL be (bpv-32)[W-1:0] when IS_FLS=1, else bpv[W-1:0].
REQ-008 BPV length L SHALL be W when use2x2=1, else 2*W.
REQ-009 out_data SHALL be: field0 in bits [127 -: W]; when use2x2=0, field1 in [127-W -: W]; then coef_bits shifted right by L; coef bits shifted past bit 0 are dropped.
REQ-010 Bits of coef_bits at positions below 128-coef_size SHALL be masked to 0 before shifting; all out_data bits below 128-out_size SHALL be 0.
REQ-011 Raw sum L+coef_size SHALL be computed on 9 bits; out_size SHALL be min(sum,128).
REQ-012 err SHALL be set when sum>128, when coef_size>128, or when IS_FLS=1 and any BPV used is outside 32..(32+2^W-1) (32..63 by default).
REQ-013 State machine SHALL have states IDLE, PACK and HOLD.
REQ-014 IDLE: in_ready=1; in_valid=1 captures all inputs into registers and moves to PACK.
REQ-015 PACK: in_ready=0; computes and registers out_data, out_size and err; moves to HOLD.
REQ-016 HOLD: out_valid=1; outputs are stable until out_ready=1, then the state goes to IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE; inputs presented in PACK or HOLD SHALL be ignored.
REQ-018 Latency SHALL be out_valid high on the 2nd rising edge after the accepting edge; maximum throughput is 1 packet per 3 cycles.
REQ-019 With out_ready held high, HOLD SHALL last exactly one cycle; with out_ready low, HOLD lasts indefinitely with no output change.
REQ-020 err SHALL NOT stall the handshake; the word is still delivered with err=1.
REQ-021 coef_size=0 SHALL give out_size=L with only the BPV field bits nonzero.

Reset
REQ-022 While rst_n=0: state IDLE, in_ready=1 after release, out_valid=0, out_data=0, out_size=0, err=0, capture registers 0.
REQ-023 Reset asserted in PACK or HOLD SHALL drop the pending packet immediately (asynchronously); no partial word is emitted afterwards.
REQ-024 The first accept is possible on the first rising edge with rst_n=1.

Verification
REQ-025 2x2: use2x2=1, bpv0=45, coef_bits=0xF0..0, coef_size=4 -> out_data[127:123]=01101, [122:119]=1111, rest 0, out_size=9, err=0.
REQ-026 2x1: use2x2=0, bpv0=32, bpv1=63, coef_size=0 -> out_data[127:118]=00000_11111, out_size=10, err=0, out_valid 2 cycles after accept.
REQ-027 Overflow: use2x2=0, coef_size=128, coef_bits all ones -> out_size=128, err=1, out_data[117:0] all ones.
REQ-028 Range: use2x2=1, bpv0=20 -> err=1, field0=(20-32)[4:0]=10100, word still delivered.
REQ-029 Backpressure: out_ready=0 for 5 cycles in HOLD while in_valid toggles -> outputs stable, in_ready=0, no capture; out_ready=1 -> IDLE next cycle.
REQ-030 Round trip: feed out_data as suffix to the BP decoder with matching use2x2 and mode -> decoded BPVs equal bpv0/bpv1 and decoded size equals out_size, for 1000 random legal packets.
